multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM for the multi-cycle 16-bit CPU.
- Sequences fetch/decode/execute/memory/writeback and drives the datapath muxes, PC/IR/register-file enables and memory strobes.
- Drives alu_op[2:0], which the ALU control decoder combines with func to select the ALU operation.
- Memory is variable-latency (mem_ready handshake), guarded by a wait timeout.

Parameters:
- MEM_TIMEOUT, 15, maximum consecutive wait cycles with mem_ready=0 before bus error (>=1).
- OPCODE_W, 4, opcode width (instr[15:12]).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- opcode  in  4  IR[15:12], valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_en  out  1  PC load enable.
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- ir_write  out  1  IR load.
- i_or_d  out  1  0 = address from PC, 1 = address from ALUOut.
- mem_read, mem_write  out  1 each  memory strobes.
- reg_write  out  1  register-file write.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = const 1, 10 = sign-extended imm, 11 = sign-extended imm (branch offset).
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 FUNC (use func field).
- halted  out  1  in HALT state.
- bus_err  out  1  sticky timeout flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (async, rst=1): state=IDLE, wait counter=0, bus_err=0.
- IDLE: all outputs 0. Next cycle goes to FETCH.
- Outputs decode from the state register. ir_write and pc_en in FETCH are additionally gated by mem_ready (Mealy). Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - When mem_ready=1: ir_write=1, pc_en=1, next state DECODE. Otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes branch target). Next state by opcode:
  - 0000 → EXEC_R.
  - 0001 (addi), 0010 (andi), 0011 (ori) → EXEC_I.
  - 0100 (lw), 0101 (sw) → MEM_ADDR.
  - 0110 (beq) → BRANCH.
  - 0111 (j) → JUMP.
  - 1111 → HALT.
  - Any other opcode → FETCH (treated as NOP).
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=FUNC → WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10; alu_op = ADD/AND/OR for 0001/0010/0011 → WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: i_or_d=1, mem_read=1. Hold until mem_ready, then → WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WR: i_or_d=1, mem_write=1. Hold until mem_ready, then → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01, pc_en=zero → FETCH.
- JUMP: pc_source=10, pc_en=1 → FETCH.
- HALT: halted=1, all strobes 0. Exit only via rst.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Cleared on entry to any wait state.
  - Increments each cycle the FSM is in a wait state with mem_ready=0; saturates.
  - If the counter equals MEM_TIMEOUT while mem_ready=0: set bus_err=1 (sticky), go to HALT.
  - If mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT, the handshake wins: normal completion, no error.
- Cycle counts: R/I-type 4, lw 5, sw 4, beq 3, j 3, each assuming mem_ready on the first cycle of every wait state.
- rst mid-operation: immediate return to IDLE. Strobes drop asynchronously; bus_err clears.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE → TRAP state. TRAP asserts output illegal_op=1 and all strobes 0; exit only via rst. state_dbg exposes the TRAP encoding.
- Undefined: undefined opcodes → FETCH (NOP); no illegal_op port.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum (4-bit encodings);
  - opcode constants OP_RTYPE..OP_HALT;
  - ALUOP_ADD/SUB/AND/OR/FUNC;
  - pc_source and alu_src_b encodings.
- One sub-module, mem_wait_timer: wait counter plus timeout compare; inputs clear/count, output expired.

Test Plan:
- Reset, then one FETCH with mem_ready=1 → IDLE 1 cycle, then FETCH with mem_read=1, ir_write=1, pc_en=1, alu_op=000.
- R-type opcode 0000 → DECODE, EXEC_R with alu_op=100, then WB_R with reg_write=1, reg_dst=1; back to FETCH after 4 cycles total.
- lw (0100) with mem_ready delayed 3 cycles in MEM_RD → mem_read held 4 cycles, then WB_MEM with mem_to_reg=1; sw (0101) → mem_write until mem_ready.
- beq (0110): zero=1 → pc_en=1 with pc_source=01 in BRANCH; zero=0 → pc_en=0. j (0111) → pc_en=1 with pc_source=10.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 → bus_err=1 and HALT at the 15th wait cycle. Variant with mem_ready=1 on that cycle → no error. rst → bus_err=0, IDLE.
- opcode 1111 → halted=1 indefinitely. Opcode 1010 → FETCH without the macro; TRAP with illegal_op=1 when CTRL_ILLEGAL_TRAP_EN is defined.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - state, opcode and datapath-select encodings for the multi-cycle control FSM
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_ORI   = 4'b0011;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JUMP  = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_AND  = 3'b010;
  localparam logic [2:0] ALUOP_OR   = 3'b011;
  localparam logic [2:0] ALUOP_FUNC = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // States that hold a memory request open until mem_ready.
  function automatic logic isWaitState(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating memory wait counter with timeout compare
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] waitCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
    end else if (clear) begin
      waitCnt <= '0;
    end else if (count && (waitCnt != CW'(LIMIT))) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  // High during the cycle whose stall would be the LIMIT-th consecutive one.
  assign expired = (waitCnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM for the multi-cycle 16-bit CPU with timed memory handshake
// Optional CTRL_ILLEGAL_TRAP_EN: undefined opcodes enter TRAP and raise illegal_op.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int OPCODE_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic [1:0]          pc_source,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_op,
  output logic                halted,
  output logic                bus_err,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                illegal_op,
`endif
  output logic [3:0]          state_dbg
);

  state_t state;
  state_t nextState;
  logic   waitClear;
  logic   waitCount;
  logic   waitExpired;
  logic   timeout;

  // Any state change clears the counter, including the MEM_WR -> FETCH hop.
  assign waitClear = (nextState != state);
  assign waitCount = isWaitState(state) && !mem_ready;
  assign timeout   = waitCount && waitExpired;

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (waitClear),
    .count  (waitCount),
    .expired(waitExpired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if (timeout) begin
      bus_err <= 1'b1;
    end
  end

  assign state_dbg = state;

  always_comb begin
    nextState  = state;
    pc_en      = 1'b0;
    pc_source  = PCSRC_ALU;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    halted     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        nextState = S_FETCH;
      end

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_en     = 1'b1;
          nextState = S_DECODE;
        end else if (timeout) begin
          nextState = S_HALT;
        end
      end

      S_DECODE: begin
        alu_src_b = SRCB_BOFF;
        case (opcode)
          OP_RTYPE:                 nextState = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI: nextState = S_EXEC_I;
          OP_LW, OP_SW:             nextState = S_MEM_ADDR;
          OP_BEQ:                   nextState = S_BRANCH;
          OP_JUMP:                  nextState = S_JUMP;
          OP_HALT:                  nextState = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                  nextState = S_TRAP;
`else
          default:                  nextState = S_FETCH;
`endif
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_FUNC;
        nextState = S_WB_R;
      end

      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        nextState = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_ANDI: alu_op = ALUOP_AND;
          OP_ORI:  alu_op = ALUOP_OR;
          default: alu_op = ALUOP_ADD;
        endcase
        nextState = S_WB_I;
      end

      S_WB_I: begin
        reg_write = 1'b1;
        nextState = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        nextState = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          nextState = S_WB_MEM;
        end else if (timeout) begin
          nextState = S_HALT;
        end
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nextState  = S_FETCH;
      end

      S_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          nextState = S_FETCH;
        end else if (timeout) begin
          nextState = S_HALT;
        end
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_en     = zero;
        nextState = S_FETCH;
      end

      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
        nextState = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_op = 1'b1;
      end
`endif

      default: begin
        nextState = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - vector table, corner sequences and random program check for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       halted;
  logic       bus_err;
  logic [3:0] state_dbg;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(15), .OPCODE_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_en     (pc_en),
    .pc_source (pc_source),
    .ir_write  (ir_write),
    .i_or_d    (i_or_d),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .mem_to_reg(mem_to_reg),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .halted    (halted),
    .bus_err   (bus_err),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state_dbg (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {pc_en, pc_source, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted, bus_err}
  logic [17:0] obs;
  assign obs = {pc_en, pc_source, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, halted, bus_err};

  localparam logic [17:0] O_IDLE   = 18'b0_00_0_0_0_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] O_FETCH  = 18'b1_00_1_0_1_0_0_0_0_0_01_000_0_0;
  localparam logic [17:0] O_FWAIT  = 18'b0_00_0_0_1_0_0_0_0_0_01_000_0_0;
  localparam logic [17:0] O_DECODE = 18'b0_00_0_0_0_0_0_0_0_0_11_000_0_0;
  localparam logic [17:0] O_EXECR  = 18'b0_00_0_0_0_0_0_0_0_1_00_100_0_0;
  localparam logic [17:0] O_WBR    = 18'b0_00_0_0_0_0_1_1_0_0_00_000_0_0;
  localparam logic [17:0] O_IMMADD = 18'b0_00_0_0_0_0_0_0_0_1_10_000_0_0;
  localparam logic [17:0] O_IMMAND = 18'b0_00_0_0_0_0_0_0_0_1_10_010_0_0;
  localparam logic [17:0] O_IMMOR  = 18'b0_00_0_0_0_0_0_0_0_1_10_011_0_0;
  localparam logic [17:0] O_WBI    = 18'b0_00_0_0_0_0_1_0_0_0_00_000_0_0;
  localparam logic [17:0] O_MEMRD  = 18'b0_00_0_1_1_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] O_WBMEM  = 18'b0_00_0_0_0_0_1_0_1_0_00_000_0_0;
  localparam logic [17:0] O_MEMWR  = 18'b0_00_0_1_0_1_0_0_0_0_00_000_0_0;
  localparam logic [17:0] O_BRT    = 18'b1_01_0_0_0_0_0_0_0_1_00_001_0_0;
  localparam logic [17:0] O_BRNT   = 18'b0_01_0_0_0_0_0_0_0_1_00_001_0_0;
  localparam logic [17:0] O_JUMP   = 18'b1_10_0_0_0_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] O_HALT   = 18'b0_00_0_0_0_0_0_0_0_0_00_000_1_0;
  localparam logic [17:0] O_HALTE  = 18'b0_00_0_0_0_0_0_0_0_0_00_000_1_1;

  typedef struct {
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] outs;
  } vec_t;

  vec_t tbl[45];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;
    opcode = 4'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic waitPhase(input int n);
    mem_ready = 1'b0;
    for (int k = 0; k < n; k++) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic z, input logic rdy,
                              input logic [3:0] st, input logic [17:0] outs);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.outs = outs;
    return v;
  endfunction

  function automatic logic [2:0] execAluFor(input logic [3:0] op);
    case (op)
      4'd0:    return 3'b100;
      4'd2:    return 3'b010;
      4'd3:    return 3'b011;
      4'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  initial begin
    tbl[0]  = mk(4'd0, 0, 0, 4'd0,  O_IDLE);
    tbl[1]  = mk(4'd0, 0, 1, 4'd1,  O_FETCH);
    tbl[2]  = mk(4'd0, 0, 1, 4'd2,  O_DECODE);
    tbl[3]  = mk(4'd0, 0, 1, 4'd3,  O_EXECR);
    tbl[4]  = mk(4'd0, 0, 1, 4'd4,  O_WBR);
    tbl[5]  = mk(4'd4, 0, 1, 4'd1,  O_FETCH);
    tbl[6]  = mk(4'd4, 0, 1, 4'd2,  O_DECODE);
    tbl[7]  = mk(4'd4, 0, 1, 4'd7,  O_IMMADD);
    tbl[8]  = mk(4'd4, 0, 0, 4'd8,  O_MEMRD);
    tbl[9]  = mk(4'd4, 0, 0, 4'd8,  O_MEMRD);
    tbl[10] = mk(4'd4, 0, 0, 4'd8,  O_MEMRD);
    tbl[11] = mk(4'd4, 0, 1, 4'd8,  O_MEMRD);
    tbl[12] = mk(4'd4, 0, 0, 4'd9,  O_WBMEM);
    tbl[13] = mk(4'd5, 0, 0, 4'd1,  O_FWAIT);
    tbl[14] = mk(4'd5, 0, 1, 4'd1,  O_FETCH);
    tbl[15] = mk(4'd5, 0, 1, 4'd2,  O_DECODE);
    tbl[16] = mk(4'd5, 0, 1, 4'd7,  O_IMMADD);
    tbl[17] = mk(4'd5, 0, 0, 4'd10, O_MEMWR);
    tbl[18] = mk(4'd5, 0, 1, 4'd10, O_MEMWR);
    tbl[19] = mk(4'd6, 0, 1, 4'd1,  O_FETCH);
    tbl[20] = mk(4'd6, 0, 1, 4'd2,  O_DECODE);
    tbl[21] = mk(4'd6, 1, 1, 4'd11, O_BRT);
    tbl[22] = mk(4'd6, 0, 1, 4'd1,  O_FETCH);
    tbl[23] = mk(4'd6, 0, 1, 4'd2,  O_DECODE);
    tbl[24] = mk(4'd6, 0, 1, 4'd11, O_BRNT);
    tbl[25] = mk(4'd7, 0, 1, 4'd1,  O_FETCH);
    tbl[26] = mk(4'd7, 0, 1, 4'd2,  O_DECODE);
    tbl[27] = mk(4'd7, 0, 1, 4'd12, O_JUMP);
    tbl[28] = mk(4'd1, 0, 1, 4'd1,  O_FETCH);
    tbl[29] = mk(4'd1, 0, 1, 4'd2,  O_DECODE);
    tbl[30] = mk(4'd1, 0, 1, 4'd5,  O_IMMADD);
    tbl[31] = mk(4'd1, 0, 1, 4'd6,  O_WBI);
    tbl[32] = mk(4'd2, 0, 1, 4'd1,  O_FETCH);
    tbl[33] = mk(4'd2, 0, 1, 4'd2,  O_DECODE);
    tbl[34] = mk(4'd2, 0, 1, 4'd5,  O_IMMAND);
    tbl[35] = mk(4'd2, 0, 1, 4'd6,  O_WBI);
    tbl[36] = mk(4'd3, 0, 1, 4'd1,  O_FETCH);
    tbl[37] = mk(4'd3, 0, 1, 4'd2,  O_DECODE);
    tbl[38] = mk(4'd3, 0, 1, 4'd5,  O_IMMOR);
    tbl[39] = mk(4'd3, 0, 1, 4'd6,  O_WBI);
    tbl[40] = mk(4'hF, 0, 1, 4'd1,  O_FETCH);
    tbl[41] = mk(4'hF, 0, 1, 4'd2,  O_DECODE);
    tbl[42] = mk(4'hF, 0, 1, 4'd13, O_HALT);
    tbl[43] = mk(4'hF, 0, 0, 4'd13, O_HALT);
    tbl[44] = mk(4'd0, 1, 1, 4'd13, O_HALT);

    rst = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    tick();
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_outs", 32'(obs), 32'(O_IDLE));
    rst = 1'b0;

    for (int i = 0; i < 45; i++) begin
      opcode = tbl[i].op; zero = tbl[i].z; mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(tbl[i].st));
      chk($sformatf("vec%0d_outs", i), 32'(obs), 32'(tbl[i].outs));
      tick();
    end

    // FETCH timeout: 15th consecutive stalled cycle halts with bus_err
    doReset();
    tick();
    mem_ready = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      #1;
      if (k == 15) begin
        chk("to_still_fetch", 32'(state_dbg), 32'd1);
        chk("to_no_err_yet", 32'(bus_err), 32'd0);
      end
      tick();
    end
    chk("to_halt_state", 32'(state_dbg), 32'd13);
    chk("to_halt_outs", 32'(obs), 32'(O_HALTE));
    mem_ready = 1'b1;
    tick(); tick();
    chk("to_halt_sticky", 32'(obs), 32'(O_HALTE));
    rst = 1'b1;
    #1;
    chk("to_async_rst_state", 32'(state_dbg), 32'd0);
    chk("to_async_rst_err", 32'(bus_err), 32'd0);
    tick();
    rst = 1'b0;

    // Handshake on the 15th stalled cycle wins over the timeout
    doReset();
    tick();
    waitPhase(14);
    chk("hs_wins_state", 32'(state_dbg), 32'd2);
    chk("hs_wins_err", 32'(bus_err), 32'd0);

    // Counter clears between consecutive wait states
    doReset();
    tick();
    opcode = 4'd4;
    waitPhase(10);
    chk("clr_lw_decode", 32'(state_dbg), 32'd2);
    tick(); tick();
    waitPhase(14);
    chk("clr_lw_wbmem", 32'(state_dbg), 32'd9);
    chk("clr_lw_err", 32'(bus_err), 32'd0);
    tick();
    opcode = 4'd5;
    waitPhase(0);
    tick(); tick();
    waitPhase(10);
    chk("clr_sw_fetch", 32'(state_dbg), 32'd1);
    waitPhase(14);
    chk("clr_sw_decode", 32'(state_dbg), 32'd2);
    chk("clr_sw_err", 32'(bus_err), 32'd0);

    // Async reset drops strobes mid MEM_RD
    doReset();
    opcode = 4'd4;
    tick();
    mem_ready = 1'b1; tick();
    mem_ready = 1'b0; tick(); tick();
    #1;
    chk("arst_memrd_before", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_memrd_after", 32'(mem_read), 32'd0);
    chk("arst_state", 32'(state_dbg), 32'd0);
    tick();
    rst = 1'b0;

    // Undefined opcode
    doReset();
    tick();
    mem_ready = 1'b1; tick();
    opcode = 4'b1010; mem_ready = 1'b0; tick();
    #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal_trap_state", 32'(state_dbg), 32'd14);
    chk("illegal_trap_flag", 32'(illegal_op), 32'd1);
    chk("illegal_trap_outs", 32'(obs), 32'(O_IDLE));
    mem_ready = 1'b1; tick(); tick();
    chk("illegal_trap_stays", 32'(state_dbg), 32'd14);
`else
    chk("illegal_nop_state", 32'(state_dbg), 32'd1);
    chk("illegal_nop_outs", 32'(obs), 32'(O_FWAIT));
`endif

    // Random program against an instruction-level model
    doReset();
    tick();
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      logic       z;
      int fl, dl, ncyc, dstart, r;
      int expRegW, expMemW, expMemR, expPcEn, expSrcA;
      int gotRegW, gotMemW, gotMemR, gotPcEn, gotIrW, gotSrcA;
      logic gotDst, gotM2r;
      logic [2:0] gotAlu;
      bit isMem, isLw, isSw;

      r = $urandom_range(0, 9);
`ifdef CTRL_ILLEGAL_TRAP_EN
      op = 4'($urandom_range(0, 7));
`else
      op = (r < 8) ? 4'(r) : 4'(8 + $urandom_range(0, 6));
`endif
      z  = 1'($urandom_range(0, 1));
      fl = $urandom_range(0, 4);
      dl = $urandom_range(0, 4);
      isLw = (op == 4'd4);
      isSw = (op == 4'd5);
      isMem = isLw || isSw;
      dstart = fl + 3;
      case (op)
        4'd0, 4'd1, 4'd2, 4'd3: ncyc = fl + 4;
        4'd4:                   ncyc = fl + dl + 5;
        4'd5:                   ncyc = fl + dl + 4;
        4'd6, 4'd7:             ncyc = fl + 3;
        default:                ncyc = fl + 2;
      endcase
      expRegW = (op <= 4'd4) ? 1 : 0;
      expMemW = isSw ? dl + 1 : 0;
      expMemR = fl + 1 + (isLw ? dl + 1 : 0);
      expPcEn = 1 + ((op == 4'd7) ? 1 : 0) + ((op == 4'd6 && z) ? 1 : 0);
      expSrcA = (op <= 4'd6) ? 1 : 0;

      gotRegW = 0; gotMemW = 0; gotMemR = 0; gotPcEn = 0; gotIrW = 0; gotSrcA = 0;
      gotDst = 1'b0; gotM2r = 1'b0; gotAlu = 3'b111;
      for (int c = 0; c < ncyc; c++) begin
        opcode = op;
        zero = z;
        if (c <= fl)
          mem_ready = (c == fl);
        else if (isMem && c >= dstart && c <= dstart + dl)
          mem_ready = (c == dstart + dl);
        else
          mem_ready = 1'($urandom_range(0, 1));
        #1;
        if (reg_write) begin gotRegW++; gotDst = reg_dst; gotM2r = mem_to_reg; end
        if (mem_write) gotMemW++;
        if (mem_read)  gotMemR++;
        if (pc_en)     gotPcEn++;
        if (ir_write)  gotIrW++;
        if (alu_src_a) begin gotSrcA++; gotAlu = alu_op; end
        tick();
      end
      mem_ready = 1'b0;
      #1;
      chk($sformatf("rnd%0d_op%0h_next_fetch", n, op), 32'(state_dbg), 32'd1);
      chk($sformatf("rnd%0d_op%0h_regw", n, op), 32'(gotRegW), 32'(expRegW));
      chk($sformatf("rnd%0d_op%0h_memw", n, op), 32'(gotMemW), 32'(expMemW));
      chk($sformatf("rnd%0d_op%0h_memr", n, op), 32'(gotMemR), 32'(expMemR));
      chk($sformatf("rnd%0d_op%0h_pcen", n, op), 32'(gotPcEn), 32'(expPcEn));
      chk($sformatf("rnd%0d_op%0h_irw", n, op), 32'(gotIrW), 32'd1);
      chk($sformatf("rnd%0d_op%0h_exec", n, op), 32'(gotSrcA), 32'(expSrcA));
      chk($sformatf("rnd%0d_op%0h_berr", n, op), 32'(bus_err), 32'd0);
      if (expRegW == 1) begin
        chk($sformatf("rnd%0d_op%0h_dst", n, op), 32'(gotDst), 32'(op == 4'd0));
        chk($sformatf("rnd%0d_op%0h_m2r", n, op), 32'(gotM2r), 32'(isLw));
      end
      if (expSrcA == 1)
        chk($sformatf("rnd%0d_op%0h_alu", n, op), 32'(gotAlu), 32'(execAluFor(op)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
